// File: rtl/ps2_host_ctrl_if.sv
// ps2_host_ctrl_if -- byte-level handshake between a PS/2 host controller and
// its client logic.
//   master : client side; drives tx_data/tx_start, observes status and rx
//   slave  : controller side; consumes tx requests, reports tx/rx results
//   tx_data[7:0]  command byte to send
//   tx_start      one-cycle send request, honoured only while tx_busy=0
//   tx_busy       transmission in flight
//   tx_done       one-cycle pulse, device acknowledged
//   tx_error      one-cycle pulse, no ack or timeout
//   rx_data[7:0]  last good received byte
//   rx_valid      one-cycle pulse when rx_data updates
//   rx_error      one-cycle pulse, framing/parity error or timeout
interface ps2_host_ctrl_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_error;

  modport master (
    output tx_data, tx_start,
    input  tx_busy, tx_done, tx_error, rx_data, rx_valid, rx_error
  );

  modport slave (
    input  tx_data, tx_start,
    output tx_busy, tx_done, tx_error, rx_data, rx_valid, rx_error
  );
endinterface

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl -- host side of a PS/2 keyboard link. Receives 11-bit
// device-to-host frames as bytes and sends host-to-device command bytes using
// the inhibit / request-to-send sequence. Both bus lines are open-drain: the
// block only ever pulls them low or releases them.
//   clock_50  system clock
//   reset     asynchronous, active-low
//   bus       byte handshake (ps2_host_ctrl_if.slave)
//   PS2_CLK   open-drain device clock
//   PS2_DAT   open-drain data
module ps2_host_ctrl #(
  parameter int FILTER_LEN     = 8,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic            clock_50,
  input  logic            reset,
  ps2_host_ctrl_if.slave  bus,
  inout  wire             PS2_CLK,
  inout  wire             PS2_DAT
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, RX_BITS, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK, TX_WAIT_IDLE
  } state_t;

  state_t        state;
  logic [1:0]    clk_sync, dat_sync;
  logic          clk_f, clk_f_d;
  logic [FW-1:0] flt_cnt;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [3:0]    bit_cnt;
  logic [9:0]    shreg;
  logic [8:0]    tx_frame;     // {parity, data}; stop is always 1
  logic          clk_oe, dat_oe;
  logic          tx_busy_r, tx_done_r, tx_error_r, rx_valid_r, rx_error_r;
  logic [7:0]    rx_data_r;

  logic       clk_s, dat_s, fall, to_run, timeout;
  logic [9:0] rx_frame;

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  assign bus.tx_busy  = tx_busy_r;
  assign bus.tx_done  = tx_done_r;
  assign bus.tx_error = tx_error_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.rx_error = rx_error_r;

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fall  = clk_f_d & ~clk_f;

  // Full frame as it stands at the stop-bit edge: {stop, parity, d7..d0}.
  assign rx_frame = {dat_s, shreg[9:1]};

  assign to_run  = (state == RX_BITS) || (state == TX_REQ) || (state == TX_BITS) ||
                   (state == TX_ACK)  || (state == TX_WAIT_IDLE);
  // An edge on the same cycle as expiry counts as activity and wins.
  assign timeout = to_run && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Synchronizers idle high (released bus) so reset does not fake an edge.
  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_f    <= 1'b1;
      clk_f_d  <= 1'b1;
      flt_cnt  <= '0;
    end else begin
      clk_sync <= {clk_sync[0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      clk_f_d  <= clk_f;
      // Filtered clock follows only after FILTER_LEN consecutive differing samples.
      if (clk_s == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      tx_frame   <= '0;
      clk_oe     <= 1'b0;
      dat_oe     <= 1'b0;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
      tx_error_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      rx_data_r  <= '0;
    end else begin
      tx_done_r  <= 1'b0;
      tx_error_r <= 1'b0;
      rx_valid_r <= 1'b0;
      rx_error_r <= 1'b0;
      to_cnt     <= (fall || !to_run) ? '0 : to_cnt + 1'b1;

      if (timeout) begin
        clk_oe <= 1'b0;
        dat_oe <= 1'b0;
        if (state == RX_BITS) begin
          rx_error_r <= 1'b1;
        end else begin
          tx_error_r <= 1'b1;
          tx_busy_r  <= 1'b0;
        end
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            // A send request beats a simultaneous start bit.
            if (bus.tx_start) begin
              tx_frame  <= {~^bus.tx_data, bus.tx_data};
              tx_busy_r <= 1'b1;
              clk_oe    <= 1'b1;
              inh_cnt   <= '0;
              state     <= TX_INHIBIT;
            end else if (fall) begin
              if (!dat_s) begin
                bit_cnt <= '0;
                state   <= RX_BITS;
              end else begin
                rx_error_r <= 1'b1;
              end
            end
          end

          RX_BITS: if (fall) begin
            if (bit_cnt == 4'd9) begin
              if (rx_frame[9] && (^rx_frame[8:0])) begin
                rx_data_r  <= rx_frame[7:0];
                rx_valid_r <= 1'b1;
              end else begin
                rx_error_r <= 1'b1;
              end
              state <= IDLE;
            end else begin
              shreg   <= rx_frame;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          // Clock is held low for INHIBIT_CYCLES in total: the exit cycle
          // below plus the TX_REQ cycle that releases it.
          TX_INHIBIT: begin
            if (inh_cnt == IW'(INHIBIT_CYCLES - 2)) begin
              dat_oe <= 1'b1;
              state  <= TX_REQ;
            end else begin
              inh_cnt <= inh_cnt + 1'b1;
            end
          end

          TX_REQ: begin
            clk_oe  <= 1'b0;
            bit_cnt <= '0;
            state   <= TX_BITS;
          end

          TX_BITS: if (fall) begin
            if (bit_cnt == 4'd9) begin
              dat_oe <= 1'b0;            // stop bit = released line
              state  <= TX_ACK;
            end else begin
              dat_oe  <= ~tx_frame[bit_cnt];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end

          TX_ACK: if (fall) begin
            if (!dat_s) begin
              state <= TX_WAIT_IDLE;
            end else begin
              tx_error_r <= 1'b1;
              tx_busy_r  <= 1'b0;
              state      <= IDLE;
            end
          end

          TX_WAIT_IDLE: if (clk_f && dat_s) begin
            tx_done_r <= 1'b1;
            tx_busy_r <= 1'b0;
            state     <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Bench for ps2_host_ctrl: a behavioural PS/2 device drives the shared
// open-drain lines. Expected bytes, parity and error outcomes come from the
// frame rules (odd parity over data+parity, stop=1), not from the RTL.
module tb_ps2_host_ctrl;
  localparam int FLT = 4;
  localparam int INH = 200;
  localparam int TMO = 3000;
  localparam int H   = 25;          // device clock half-period in clock_50 cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  wire  ps2_clk, ps2_dat;

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_host_ctrl_if bus ();

  ps2_host_ctrl #(.FILTER_LEN(FLT), .INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_50 (clk),
    .reset    (rst_n),
    .bus      (bus),
    .PS2_CLK  (ps2_clk),
    .PS2_DAT  (ps2_dat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int rxv_n = 0, rxe_n = 0, txd_n = 0, txe_n = 0, viol_n = 0;
  logic [3:0] prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse accounting plus one-cycle-width / exclusivity tracking.
  always @(negedge clk) begin
    if (bus.rx_valid) rxv_n <= rxv_n + 1;
    if (bus.rx_error) rxe_n <= rxe_n + 1;
    if (bus.tx_done)  txd_n <= txd_n + 1;
    if (bus.tx_error) txe_n <= txe_n + 1;
    if ((prev[0] && bus.rx_valid) || (prev[1] && bus.rx_error) ||
        (prev[2] && bus.tx_done) || (prev[3] && bus.tx_error) ||
        (bus.tx_done && bus.tx_error))
      viol_n <= viol_n + 1;
    prev <= {bus.tx_error, bus.tx_done, bus.rx_error, bus.rx_valid};
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d..%0d", nm, act, lo, hi);
    end
  endtask

  // Device-to-host: fr[0] is the start bit, sent first.
  task automatic dev_send(input logic [10:0] fr, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dev_dat_low = ~fr[i];
      cyc_wait(H);
      dev_clk_low = 1'b1;
      last_fall = cyc;
      cyc_wait(H);
      dev_clk_low = 1'b0;
    end
    cyc_wait(H);
    dev_dat_low = 1'b0;
  endtask

  task automatic rx_frame_chk(input string tag, input logic [7:0] b, input logic par,
                              input logic stop, input logic ev, input logic ee,
                              input logic [7:0] ed);
    int v0, e0;
    v0 = rxv_n; e0 = rxe_n;
    dev_send({stop, par, b, 1'b0}, 11);
    cyc_wait(10);
    chk({tag, "_valid"}, rxv_n - v0, {31'd0, ev});
    chk({tag, "_err"},   rxe_n - e0, {31'd0, ee});
    chk({tag, "_data"},  {24'd0, bus.rx_data}, {24'd0, ed});
  endtask

  // Host-to-device: watch the inhibit, then clock the frame out of the host.
  task automatic dev_host_rx(input bit give_ack, output logic [9:0] got, output int low_len,
                             output bit start_ok, output bit busy_ok);
    int t;
    got = '0; low_len = 0; start_ok = 0; busy_ok = 1; t = 0;
    while (ps2_clk !== 1'b0 && t < 100) begin cyc_wait(1); t++; end
    while (ps2_clk === 1'b0 && low_len < 4 * INH) begin cyc_wait(1); low_len++; end
    start_ok = (ps2_dat === 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc_wait(H); dev_clk_low = 1'b1;
      cyc_wait(H); dev_clk_low = 1'b0;
      cyc_wait(2);
      got[i] = ps2_dat;
      if (bus.tx_busy !== 1'b1) busy_ok = 0;
    end
    cyc_wait(H / 2); dev_dat_low = give_ack;
    cyc_wait(H / 2); dev_clk_low = 1'b1;
    cyc_wait(H);     dev_clk_low = 1'b0;
    cyc_wait(2);     dev_dat_low = 1'b0;
  endtask

  task automatic run_tx(input logic [7:0] b, input bit ack);
    int d0, e0, t, low;
    logic [9:0] got;
    bit st, busy;
    logic par;
    d0 = txd_n; e0 = txe_n;
    bus.tx_data = b; bus.tx_start = 1'b1;
    cyc_wait(1);
    bus.tx_start = 1'b0;
    chk("tx_busy_set", {31'd0, bus.tx_busy}, 1);
    dev_host_rx(ack, got, low, st, busy);
    par = ($countones(b) % 2 == 0);
    chk_rng("tx_inhibit_len", low, INH - 1, INH + 1);
    chk("tx_start_bit", {31'd0, st}, 1);
    chk("tx_frame", {22'd0, got}, {22'd0, 1'b1, par, b});
    chk("tx_busy_cover", {31'd0, busy}, 1);
    t = 0;
    while (txd_n == d0 && txe_n == e0 && t < 300) begin cyc_wait(1); t++; end
    cyc_wait(2);
    chk("tx_done_cnt", txd_n - d0, ack ? 1 : 0);
    chk("tx_err_cnt",  txe_n - e0, ack ? 0 : 1);
    chk("tx_busy_clr", {31'd0, bus.tx_busy}, 0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       par;
    logic       stop;
    logic       ev;
    logic       ee;
    logic [7:0] ed;
  } rx_vec_t;

  initial begin
    rx_vec_t    vecs [8];
    logic [7:0] model_data;
    int v0, e0, d0, t0, t, dt;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 8'h1C};  // bad parity
    vecs[2] = '{8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA};
    vecs[3] = '{8'hFA, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFA};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
    vecs[5] = '{8'hF0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};  // bad stop
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 8'hFF};
    vecs[7] = '{8'h12, 1'b0, 1'b1, 1'b0, 1'b1, 8'hFF};  // bad parity

    bus.tx_data = '0; bus.tx_start = 1'b0;
    cyc_wait(5);
    chk("reset_outputs", {19'd0, bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_valid,
                          bus.rx_error, bus.rx_data}, 0);
    chk("reset_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    rst_n = 1'b1;
    cyc_wait(20);

    foreach (vecs[i])
      rx_frame_chk("tbl_rx", vecs[i].b, vecs[i].par, vecs[i].stop,
                   vecs[i].ev, vecs[i].ee, vecs[i].ed);
    model_data = vecs[7].ed;

    for (int i = 0; i < 16; i++) begin
      logic [7:0] b;
      logic par, stop, ok;
      int kind;
      b = 8'($urandom);
      kind = $urandom_range(0, 3);
      par  = ($countones(b) % 2 == 0);
      if (kind == 2) par = ~par;
      stop = (kind != 3);
      ok   = stop && (($countones(b) + par) % 2 == 1);
      if (ok) model_data = b;
      rx_frame_chk("rand_rx", b, par, stop, ok, ~ok, model_data);
    end

    // Short low glitch with data high: would raise rx_error if it got through.
    v0 = rxv_n; e0 = rxe_n;
    dev_dat_low = 1'b0; dev_clk_low = 1'b1;
    cyc_wait(3);
    dev_clk_low = 1'b0;
    cyc_wait(40);
    chk("glitch_err", rxe_n - e0, 0);
    chk("glitch_valid", rxv_n - v0, 0);
    rx_frame_chk("post_glitch", 8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 8'h1C);

    run_tx(8'hED, 1'b1);
    run_tx(8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) run_tx(8'($urandom), 1'b1);

    // Device stalls after 4 bits of a frame.
    v0 = rxv_n; e0 = rxe_n;
    dev_send({1'b1, 1'b1, 8'hAA, 1'b0}, 4);
    t = 0;
    while (rxe_n == e0 && t < TMO + 500) begin cyc_wait(1); t++; end
    dt = cyc - last_fall;
    chk("timeout_err", rxe_n - e0, 1);
    chk("timeout_valid", rxv_n - v0, 0);
    chk_rng("timeout_delay", dt, TMO, TMO + FLT + 12);
    rx_frame_chk("after_timeout", 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 8'hAA);

    // Reset in the middle of a transmission.
    v0 = rxv_n; e0 = rxe_n; d0 = txd_n; t0 = txe_n;
    bus.tx_data = 8'h55; bus.tx_start = 1'b1;
    cyc_wait(1);
    bus.tx_start = 1'b0;
    t = 0;
    while (ps2_clk !== 1'b0 && t < 100) begin cyc_wait(1); t++; end
    t = 0;
    while (ps2_clk === 1'b0 && t < 4 * INH) begin cyc_wait(1); t++; end
    for (int i = 0; i < 2; i++) begin
      cyc_wait(H); dev_clk_low = 1'b1;
      cyc_wait(H); dev_clk_low = 1'b0;
    end
    cyc_wait(2);
    chk("pre_reset_dat", {31'd0, ps2_dat}, 0);   // host presenting d1=0
    rst_n = 1'b0;
    #1;
    chk("rst_lines", {30'd0, ps2_clk, ps2_dat}, 3);
    chk("rst_outputs", {19'd0, bus.tx_busy, bus.tx_done, bus.tx_error, bus.rx_valid,
                        bus.rx_error, bus.rx_data}, 0);
    cyc_wait(10);
    rst_n = 1'b1;
    cyc_wait(20);
    chk("rst_no_pulse", (rxe_n - e0) + (txe_n - t0) + (txd_n - d0) + (rxv_n - v0), 0);

    chk("pulse_rules", viol_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
